regwin_stack_file: RTL and testbench

Parametrised windowed register file with a circular physical array, an internal current-window pointer, and automatic spill/fill of window frames to a backing stack memory. It sits in the CPU datapath in place of the fixed-window register file. The control unit issues `call` and `ret` and stalls on `busy`. Spills and fills use a req/ack memory port.

---
 rtl/regwin_pkg.sv | 16 +
 rtl/regwin_ctrl.sv | 85 ++++++++
 rtl/regwin_stack_file.sv | 69 ++++++
 tb/tb_regwin_stack_file.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regwin_pkg.sv
// regwin_pkg: shared state enum, parameter defaults and window-to-physical index mapping
package regwin_pkg;
  typedef enum logic [1:0] {IDLE, SPILL, FILL} state_t;
  localparam int DW_DEF = 16;
  localparam int FRAME_DEF = 2;
  localparam int NWIN_DEF = 4;
  localparam int MAXD_DEF = 8;
  localparam int MAW_DEF = 8;
  localparam int P_DEF = NWIN_DEF * FRAME_DEF;
  localparam int AW_DEF = $clog2(2 * FRAME_DEF);
  localparam int CW_DEF = $clog2(NWIN_DEF);
  // Register r of window win lives at (win*frame + r) mod P, wrapping round the circular array.
  function automatic int physIdx(input int win, input int r, input int frame, input int nwin);
    return (win * frame + r) % (frame * nwin);
  endfunction
endpackage

// File: rtl/regwin_ctrl.sv
// regwin_ctrl: window FSM, cwp/bot/depth counters and spill/fill memory port
// Ports: clk/rst; call/ret requests; mem_ack and spillData (phys[frameIdx]) in;
//   busy, err, cwp, mem_req/mem_we/mem_addr/mem_wdata out; fillWe/frameIdx steer fill writes.
module regwin_ctrl
  import regwin_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int FRAME = FRAME_DEF,
  parameter int NWIN = NWIN_DEF,
  parameter int MAXD = MAXD_DEF,
  parameter int MAW = MAW_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              call,
  input  logic                              ret,
  input  logic                              mem_ack,
  input  logic [DW-1:0]                     spillData,
  output logic                              busy,
  output logic                              err,
  output logic [$clog2(NWIN)-1:0]           cwp,
  output logic                              mem_req,
  output logic                              mem_we,
  output logic [MAW-1:0]                    mem_addr,
  output logic [DW-1:0]                     mem_wdata,
  output logic                              fillWe,
  output logic [$clog2(NWIN*FRAME)-1:0]     frameIdx
);
  localparam int CW = $clog2(NWIN);
  localparam int DPW = $clog2(MAXD + 1);
  localparam int BW = FRAME > 1 ? $clog2(FRAME) : 1;
  localparam int PW = $clog2(NWIN * FRAME);
  state_t state;
  logic [CW-1:0] bot;
  logic [CW-1:0] fillBot;
  logic [DPW-1:0] depth;
  logic [BW-1:0] beat;
  logic full;
  logic empty;
  logic lastBeat;
  // Resident frames = (cwp - bot) mod NWIN + 2, so full/empty reduce to the raw distance.
  assign full = (cwp - bot) == CW'(NWIN - 2);
  assign empty = cwp == bot;
  assign lastBeat = beat == BW'(FRAME - 1);
  assign fillBot = bot - CW'(1);
  assign busy = state != IDLE;
  assign mem_req = busy;
  assign mem_we = state == SPILL;
  assign mem_addr = busy ? MAW'(32'(state == FILL ? depth - DPW'(1) : depth) * FRAME + 32'(beat)) : '0;
  assign mem_wdata = state == SPILL ? spillData : '0;
  // Spill drains the oldest resident frame; fill restores the frame just below it.
  assign frameIdx = PW'(physIdx(32'(state == FILL ? fillBot : bot), 32'(beat), FRAME, NWIN));
  assign fillWe = state == FILL && mem_ack;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cwp <= '0;
      bot <= '0;
      depth <= '0;
      beat <= '0;
      err <= 1'b0;
    end else begin
      err <= 1'b0;
      if (state == IDLE) begin
        if (call && ret) err <= 1'b1;
        else if (call) begin
          if (!full) cwp <= cwp + CW'(1);
          else if (depth != DPW'(MAXD)) state <= SPILL;
          else err <= 1'b1;
        end else if (ret) begin
          if (!empty) cwp <= cwp - CW'(1);
          else if (depth != '0) state <= FILL;
          else err <= 1'b1;
        end
      end else if (mem_ack) begin
        beat <= lastBeat ? '0 : beat + BW'(1);
        if (lastBeat) begin
          state <= IDLE;
          cwp <= state == SPILL ? cwp + CW'(1) : cwp - CW'(1);
          bot <= state == SPILL ? bot + CW'(1) : fillBot;
          depth <= state == SPILL ? depth + DPW'(1) : depth - DPW'(1);
        end
      end
    end
endmodule

// File: rtl/regwin_stack_file.sv
// regwin_stack_file: windowed register file on a circular array with spill/fill to a backing stack
// Ports: clk/rst; rd_addr_a/b -> rd_data_a/b (combinational, also while busy);
//   wr_en/wr_addr/wr_data; call/ret -> busy, err, cwp; mem_* req/ack backing-memory port.
module regwin_stack_file
  import regwin_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int FRAME = FRAME_DEF,
  parameter int NWIN = NWIN_DEF,
  parameter int MAXD = MAXD_DEF,
  parameter int MAW = MAW_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [$clog2(2*FRAME)-1:0]    rd_addr_a,
  input  logic [$clog2(2*FRAME)-1:0]    rd_addr_b,
  output logic [DW-1:0]                 rd_data_a,
  output logic [DW-1:0]                 rd_data_b,
  input  logic                          wr_en,
  input  logic [$clog2(2*FRAME)-1:0]    wr_addr,
  input  logic [DW-1:0]                 wr_data,
  input  logic                          call,
  input  logic                          ret,
  output logic                          busy,
  output logic                          err,
  output logic [$clog2(NWIN)-1:0]       cwp,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [MAW-1:0]                mem_addr,
  output logic [DW-1:0]                 mem_wdata,
  input  logic [DW-1:0]                 mem_rdata,
  input  logic                          mem_ack
);
  localparam int P = NWIN * FRAME;
  localparam int PW = $clog2(P);
  logic [DW-1:0] phys [P];
  logic [PW-1:0] rdIdxA;
  logic [PW-1:0] rdIdxB;
  logic [PW-1:0] wrIdx;
  logic [PW-1:0] frameIdx;
  logic fillWe;
  regwin_ctrl #(.DW(DW), .FRAME(FRAME), .NWIN(NWIN), .MAXD(MAXD), .MAW(MAW)) ctrl (
    .clk(clk),
    .rst(rst),
    .call(call),
    .ret(ret),
    .mem_ack(mem_ack),
    .spillData(phys[frameIdx]),
    .busy(busy),
    .err(err),
    .cwp(cwp),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .fillWe(fillWe),
    .frameIdx(frameIdx)
  );
  assign rdIdxA = PW'(physIdx(32'(cwp), 32'(rd_addr_a), FRAME, NWIN));
  assign rdIdxB = PW'(physIdx(32'(cwp), 32'(rd_addr_b), FRAME, NWIN));
  assign wrIdx = PW'(physIdx(32'(cwp), 32'(wr_addr), FRAME, NWIN));
  assign rd_data_a = phys[rdIdxA];
  assign rd_data_b = phys[rdIdxB];
  // Fill beats only occur while busy, when ordinary writes are blocked, so the two never collide.
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int k = 0; k < P; k++) phys[k] <= '0;
    else if (fillWe) phys[frameIdx] <= mem_rdata;
    else if (wr_en && !busy) phys[wrIdx] <= wr_data;
endmodule

// File: tb/tb_regwin_stack_file.sv
// tb_regwin_stack_file: vector table, handshake corner cases and randomized model check
module tb_regwin_stack_file;
  import regwin_pkg::*;
  localparam int DW = 16, FRAME = 2, NWIN = 4, MAXD = 8, MAW = 8, P = P_DEF;
  logic clk = 1'b0, rst = 1'b0;
  logic [AW_DEF-1:0] rd_addr_a, rd_addr_b, wr_addr;
  logic [DW-1:0] rd_data_a, rd_data_b, wr_data, mem_wdata, mem_rdata;
  logic wr_en, call, ret, busy, err, mem_req, mem_we, mem_ack;
  logic [CW_DEF-1:0] cwp;
  logic [MAW-1:0] mem_addr;
  logic [DW-1:0] bmem [256];
  int checks = 0, errors = 0;

  typedef struct {
    logic c, r, we;
    logic [1:0] wa;
    logic [15:0] wd;
    logic [1:0] ra, rb;
    logic [1:0] eCwp;
    logic eBusy, eErr, eReq, eWe;
    logic [7:0] eAddr;
    logic [15:0] eWd, eA, eB;
  } vec_t;
  vec_t tbl[$];

  int mL, mD, mMode, mBeat;
  logic mErr;
  logic [15:0] mp [P];
  logic [15:0] mm [MAXD*FRAME];

  always #5 clk = ~clk;

  regwin_stack_file dut (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .call(call), .ret(ret), .busy(busy), .err(err), .cwp(cwp),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  assign mem_rdata = bmem[mem_addr];
  always @(posedge clk) if (mem_req && mem_we && mem_ack) bmem[mem_addr] <= mem_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    call = 0; ret = 0; wr_en = 0; wr_addr = 0; wr_data = 0; rd_addr_a = 0; rd_addr_b = 0;
  endtask

  task automatic doReset();
    idle();
    mem_ack = 0;
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic chkResetOuts(input string tag);
    chk({tag, ".cwp"}, 32'(cwp), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".err"}, 32'(err), 0);
    chk({tag, ".mem_req"}, 32'(mem_req), 0);
    chk({tag, ".mem_we"}, 32'(mem_we), 0);
    chk({tag, ".mem_addr"}, 32'(mem_addr), 0);
    chk({tag, ".mem_wdata"}, 32'(mem_wdata), 0);
    chk({tag, ".rd_a"}, 32'(rd_data_a), 0);
  endtask

  task automatic add(input logic c, r, we, input logic [1:0] wa, input logic [15:0] wd,
                     input logic [1:0] ra, rb, input logic [1:0] eCwp, input logic eBusy, eErr, eReq, eWe,
                     input logic [7:0] eAddr, input logic [15:0] eWd, eA, eB);
    vec_t v;
    v.c = c; v.r = r; v.we = we; v.wa = wa; v.wd = wd; v.ra = ra; v.rb = rb;
    v.eCwp = eCwp; v.eBusy = eBusy; v.eErr = eErr; v.eReq = eReq; v.eWe = eWe;
    v.eAddr = eAddr; v.eWd = eWd; v.eA = eA; v.eB = eB;
    tbl.push_back(v);
  endtask

  task automatic modelReset();
    mL = 0; mD = 0; mMode = 0; mBeat = 0; mErr = 0;
    for (int k = 0; k < P; k++) mp[k] = '0;
  endtask

  // Frames are tracked by absolute call level L; frame k lives in slot k mod NWIN, spilled frame k at mm[k*FRAME].
  task automatic modelCheck(input int n);
    int eAddr;
    logic [15:0] eWd;
    eAddr = mMode == 1 ? mD * FRAME + mBeat : mMode == 2 ? (mD - 1) * FRAME + mBeat : 0;
    eWd = mMode == 1 ? mp[(mD % NWIN) * FRAME + mBeat] : 16'h0;
    chk($sformatf("rnd%0d.cwp", n), 32'(cwp), 32'(mL % NWIN));
    chk($sformatf("rnd%0d.busy", n), 32'(busy), 32'(mMode != 0));
    chk($sformatf("rnd%0d.err", n), 32'(err), 32'(mErr));
    chk($sformatf("rnd%0d.mem_req", n), 32'(mem_req), 32'(mMode != 0));
    chk($sformatf("rnd%0d.mem_we", n), 32'(mem_we), 32'(mMode == 1));
    chk($sformatf("rnd%0d.mem_addr", n), 32'(mem_addr), 32'(eAddr));
    chk($sformatf("rnd%0d.mem_wdata", n), 32'(mem_wdata), 32'(eWd));
    chk($sformatf("rnd%0d.rd_a", n), 32'(rd_data_a), 32'(mp[(mL * FRAME + int'(rd_addr_a)) % P]));
    chk($sformatf("rnd%0d.rd_b", n), 32'(rd_data_b), 32'(mp[(mL * FRAME + int'(rd_addr_b)) % P]));
  endtask

  task automatic modelStep();
    logic e;
    e = 0;
    if (mMode == 0) begin
      if (wr_en) mp[(mL * FRAME + int'(wr_addr)) % P] = wr_data;
      if (call && ret) e = 1;
      else if (call) begin
        if (mL - mD + 2 < NWIN) mL++;
        else if (mD < MAXD) begin mMode = 1; mBeat = 0; end
        else e = 1;
      end else if (ret) begin
        if (mL > mD) mL--;
        else if (mD > 0) begin mMode = 2; mBeat = 0; end
        else e = 1;
      end
    end else if (mem_ack) begin
      if (mMode == 1) mm[mD * FRAME + mBeat] = mp[(mD % NWIN) * FRAME + mBeat];
      else mp[((mD - 1) % NWIN) * FRAME + mBeat] = mm[(mD - 1) * FRAME + mBeat];
      mBeat++;
      if (mBeat == FRAME) begin
        if (mMode == 1) begin mD++; mL++; end
        else begin mD--; mL--; end
        mMode = 0;
        mBeat = 0;
      end
    end
    mErr = e;
  endtask

  initial begin
    idle();
    mem_ack = 0;
    rst = 1;
    #1;
    chkResetOuts("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 0;

    //   c  r  we wa wd        ra rb | cwp busy err req we addr wdata     A         B
    add(0, 0, 1, 0, 16'h1111, 0, 3,  0, 0, 0, 0, 0, 8'd0, 16'h0000, 16'h1111, 16'h0000);
    add(0, 0, 1, 1, 16'h2222, 0, 1,  0, 0, 0, 0, 0, 8'd0, 16'h0000, 16'h1111, 16'h2222);
    add(0, 0, 1, 3, 16'h3333, 0, 3,  0, 0, 0, 0, 0, 8'd0, 16'h0000, 16'h1111, 16'h3333);
    add(1, 0, 0, 0, 16'h0000, 1, 0,  1, 0, 0, 0, 0, 8'd0, 16'h0000, 16'h3333, 16'h0000);
    add(0, 0, 1, 2, 16'hAAAA, 2, 3,  1, 0, 0, 0, 0, 8'd0, 16'h0000, 16'hAAAA, 16'h0000);
    add(0, 0, 1, 3, 16'hBBBB, 1, 3,  1, 0, 0, 0, 0, 8'd0, 16'h0000, 16'h3333, 16'hBBBB);
    add(1, 0, 0, 0, 16'h0000, 0, 1,  2, 0, 0, 0, 0, 8'd0, 16'h0000, 16'hAAAA, 16'hBBBB);
    add(1, 0, 0, 0, 16'h0000, 0, 2,  2, 1, 0, 1, 1, 8'd0, 16'h1111, 16'hAAAA, 16'h0000);
    add(0, 0, 1, 0, 16'h9999, 0, 1,  2, 1, 0, 1, 1, 8'd1, 16'h2222, 16'hAAAA, 16'hBBBB);
    add(0, 0, 0, 0, 16'h0000, 0, 2,  3, 0, 0, 0, 0, 8'd0, 16'h0000, 16'h0000, 16'h1111);
    add(0, 0, 1, 3, 16'hBEEF, 3, 2,  3, 0, 0, 0, 0, 8'd0, 16'h0000, 16'hBEEF, 16'h1111);
    add(0, 1, 1, 2, 16'hDEAD, 0, 2,  2, 0, 0, 0, 0, 8'd0, 16'h0000, 16'hAAAA, 16'h0000);
    add(0, 1, 0, 0, 16'h0000, 0, 1,  1, 0, 0, 0, 0, 8'd0, 16'h0000, 16'h0000, 16'h3333);
    add(0, 1, 0, 0, 16'h0000, 0, 1,  1, 1, 0, 1, 0, 8'd0, 16'h0000, 16'h0000, 16'h3333);
    add(0, 0, 0, 0, 16'h0000, 0, 1,  1, 1, 0, 1, 0, 8'd1, 16'h0000, 16'h0000, 16'h3333);
    add(0, 0, 0, 0, 16'h0000, 0, 1,  0, 0, 0, 0, 0, 8'd0, 16'h0000, 16'h1111, 16'h2222);
    add(0, 1, 0, 0, 16'h0000, 0, 3,  0, 0, 1, 0, 0, 8'd0, 16'h0000, 16'h1111, 16'h3333);
    add(1, 1, 1, 3, 16'h7777, 0, 3,  0, 0, 1, 0, 0, 8'd0, 16'h0000, 16'h1111, 16'h7777);
    add(0, 0, 0, 0, 16'h0000, 0, 3,  0, 0, 0, 0, 0, 8'd0, 16'h0000, 16'h1111, 16'h7777);

    mem_ack = 1;
    foreach (tbl[i]) begin
      call = tbl[i].c; ret = tbl[i].r; wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      rd_addr_a = tbl[i].ra; rd_addr_b = tbl[i].rb;
      @(negedge clk);
      chk($sformatf("row%0d.cwp", i), 32'(cwp), 32'(tbl[i].eCwp));
      chk($sformatf("row%0d.busy", i), 32'(busy), 32'(tbl[i].eBusy));
      chk($sformatf("row%0d.err", i), 32'(err), 32'(tbl[i].eErr));
      chk($sformatf("row%0d.mem_req", i), 32'(mem_req), 32'(tbl[i].eReq));
      chk($sformatf("row%0d.mem_we", i), 32'(mem_we), 32'(tbl[i].eWe));
      chk($sformatf("row%0d.mem_addr", i), 32'(mem_addr), 32'(tbl[i].eAddr));
      chk($sformatf("row%0d.mem_wdata", i), 32'(mem_wdata), 32'(tbl[i].eWd));
      chk($sformatf("row%0d.rd_a", i), 32'(rd_data_a), 32'(tbl[i].eA));
      chk($sformatf("row%0d.rd_b", i), 32'(rd_data_b), 32'(tbl[i].eB));
    end

    // Stalled spill: ack held low, request stays stable, requests during busy ignored.
    doReset();
    wr_en = 1; wr_addr = 0; wr_data = 16'h1234;
    @(negedge clk);
    wr_en = 0; call = 1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    call = 0;
    chk("stall.enter_busy", 32'(busy), 1);
    for (int k = 0; k < 5; k++) begin
      wr_en = 1; wr_addr = 2; wr_data = 16'h5A5A; call = (k == 2);
      @(negedge clk);
      chk($sformatf("stall%0d.busy", k), 32'(busy), 1);
      chk($sformatf("stall%0d.mem_addr", k), 32'(mem_addr), 0);
      chk($sformatf("stall%0d.mem_wdata", k), 32'(mem_wdata), 32'h1234);
      chk($sformatf("stall%0d.cwp", k), 32'(cwp), 2);
      chk($sformatf("stall%0d.err", k), 32'(err), 0);
    end
    wr_en = 0; call = 0; mem_ack = 1;
    @(negedge clk);
    chk("stall.beat1_addr", 32'(mem_addr), 1);
    @(negedge clk);
    chk("stall.done_busy", 32'(busy), 0);
    chk("stall.done_cwp", 32'(cwp), 3);
    rd_addr_a = 0;
    #1;
    chk("stall.write_blocked", 32'(rd_data_a), 0);

    // Reset in the middle of the second fill beat.
    ret = 1;
    @(negedge clk);
    chk("fillrst.cwp2", 32'(cwp), 2);
    @(negedge clk);
    chk("fillrst.cwp1", 32'(cwp), 1);
    @(negedge clk);
    ret = 0;
    chk("fillrst.busy", 32'(busy), 1);
    chk("fillrst.we", 32'(mem_we), 0);
    chk("fillrst.addr0", 32'(mem_addr), 0);
    @(negedge clk);
    chk("fillrst.addr1", 32'(mem_addr), 1);
    rst = 1;
    #1;
    chkResetOuts("fillrst");
    @(negedge clk);
    rst = 0;
    call = 1;
    @(negedge clk);
    call = 0;
    chk("fillrst.call_cwp", 32'(cwp), 1);
    chk("fillrst.call_busy", 32'(busy), 0);

    // Randomized run against the level/depth model, alternating call-heavy and ret-heavy phases.
    doReset();
    modelReset();
    for (int n = 0; n < 4000; n++) begin
      int pc, pr;
      pc = ((n / 200) % 2 == 0) ? 45 : 15;
      pr = ((n / 200) % 2 == 0) ? 15 : 45;
      call = $urandom_range(0, 99) < pc;
      ret = $urandom_range(0, 99) < pr;
      wr_en = $urandom_range(0, 1) == 1;
      wr_addr = 2'($urandom_range(0, 3));
      wr_data = 16'($urandom);
      rd_addr_a = 2'($urandom_range(0, 3));
      rd_addr_b = 2'($urandom_range(0, 3));
      mem_ack = mem_req && ($urandom_range(0, 2) != 0);
      #1;
      modelCheck(n);
      @(posedge clk);
      modelStep();
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
